// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for a 1-bit ALU slice: latches operands, walks them LSB first
// through the external slice, and assembles the result plus zero/carry/overflow flags.
module alu_serial_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_carry_in,
    output logic [3:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_carry_out
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg, res_sr_reg;
    logic [3:0]       op_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg, carry_out_reg, overflow_reg;

    logic             last_bit;
    logic [WIDTH-1:0] res_next, result_next;
    logic             ovf_next, slt_bit;

    assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Slice outputs for the MSB are consumed in the same cycle that forms the final flags.
    assign res_next    = {slice_result, res_sr_reg[WIDTH-1:1]};
    assign ovf_next    = op_reg[1] & (carry_reg ^ slice_carry_out);
    assign slt_bit     = res_next[WIDTH-1] ^ ovf_next;
    assign result_next = (op_reg[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, slt_bit} : res_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            carry_reg     <= 1'b0;
            res_sr_reg    <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    a_reg     <= a;
                    b_reg     <= b;
                    op_reg    <= alu_op;
                    cnt_reg   <= '0;
                    carry_reg <= alu_op[2]; // Bnegate supplies the two's-complement +1
                end
                RUN: begin
                    res_sr_reg <= res_next;
                    carry_reg  <= slice_carry_out;
                    if (last_bit) begin
                        result_reg    <= result_next;
                        zero_reg      <= (result_next == '0);
                        carry_out_reg <= slice_carry_out;
                        overflow_reg  <= ovf_next;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result         = result_reg;
    assign zero           = zero_reg;
    assign carry_out      = carry_out_reg;
    assign overflow       = overflow_reg;
    assign slice_a        = a_reg[cnt_reg];
    assign slice_b        = b_reg[cnt_reg];
    assign slice_carry_in = carry_reg;
    assign slice_op       = {op_reg[3:2], (op_reg[1:0] == 2'b11) ? 2'b10 : op_reg[1:0]};
endmodule
